tc_ps_acp_rw: RTL and testbench

Parametrised AXI3 burst master for the Zynq PS ACP slave port, superseding the fixed 64-bit write/read pair. It provides independent, concurrently operating write and read engines: each issues a single-ID INCR burst of a configurable length, and each returns a completion pulse with an error flag. It sits between fabric producers/consumers and the PS `S_AXI_ACP_0_*` pins.

---
 rtl/tc_ps_acp_rw.sv | 246 ++++++++++++++++++++++++
 tb/tb_tc_ps_acp_rw.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_ps_acp_rw.sv
// AXI3 burst master for the Zynq PS ACP port: independent write and read
// engines, each issuing one single-ID INCR burst and reporting done/error.
module tc_ps_acp_rw #(
   parameter int          DATA_W    = 64,
   parameter int          ID_W      = 3,
   parameter int          BURST_LEN = 16,
   parameter logic [3:0]  AXCACHE   = 4'b1111,
   parameter logic [4:0]  AXUSER    = 5'b00001
) (
   input  logic                 clk,
   input  logic                 rst,
   // write request side
   input  logic                 tx_en,
   output logic                 tx_rdy,
   input  logic [31:0]          tx_awaddr,
   input  logic [ID_W-1:0]      tx_awid,
   input  logic [DATA_W-1:0]    tx_wdata,
   output logic                 tx_wdreq,
   output logic                 tx_done,
   output logic                 tx_err,
   // read request side
   input  logic                 rx_en,
   output logic                 rx_rdy,
   input  logic [31:0]          rx_araddr,
   input  logic [ID_W-1:0]      rx_arid,
   output logic [DATA_W-1:0]    rx_rdata,
   output logic                 rx_rvalid,
   output logic                 rx_done,
   output logic                 rx_err,
   // AW
   output logic                 S_AXI_ACP_0_AWVALID,
   input  logic                 S_AXI_ACP_0_AWREADY,
   output logic [31:0]          S_AXI_ACP_0_AWADDR,
   output logic [ID_W-1:0]      S_AXI_ACP_0_AWID,
   output logic [3:0]           S_AXI_ACP_0_AWLEN,
   output logic [2:0]           S_AXI_ACP_0_AWSIZE,
   output logic [1:0]           S_AXI_ACP_0_AWBURST,
   output logic [1:0]           S_AXI_ACP_0_AWLOCK,
   output logic [3:0]           S_AXI_ACP_0_AWCACHE,
   output logic [2:0]           S_AXI_ACP_0_AWPROT,
   output logic [3:0]           S_AXI_ACP_0_AWQOS,
   output logic [4:0]           S_AXI_ACP_0_AWUSER,
   // W
   output logic                 S_AXI_ACP_0_WVALID,
   input  logic                 S_AXI_ACP_0_WREADY,
   output logic [DATA_W-1:0]    S_AXI_ACP_0_WDATA,
   output logic [DATA_W/8-1:0]  S_AXI_ACP_0_WSTRB,
   output logic                 S_AXI_ACP_0_WLAST,
   output logic [ID_W-1:0]      S_AXI_ACP_0_WID,
   // B
   input  logic                 S_AXI_ACP_0_BVALID,
   output logic                 S_AXI_ACP_0_BREADY,
   input  logic [1:0]           S_AXI_ACP_0_BRESP,
   input  logic [ID_W-1:0]      S_AXI_ACP_0_BID,
   // AR
   output logic                 S_AXI_ACP_0_ARVALID,
   input  logic                 S_AXI_ACP_0_ARREADY,
   output logic [31:0]          S_AXI_ACP_0_ARADDR,
   output logic [ID_W-1:0]      S_AXI_ACP_0_ARID,
   output logic [3:0]           S_AXI_ACP_0_ARLEN,
   output logic [2:0]           S_AXI_ACP_0_ARSIZE,
   output logic [1:0]           S_AXI_ACP_0_ARBURST,
   output logic [1:0]           S_AXI_ACP_0_ARLOCK,
   output logic [3:0]           S_AXI_ACP_0_ARCACHE,
   output logic [2:0]           S_AXI_ACP_0_ARPROT,
   output logic [3:0]           S_AXI_ACP_0_ARQOS,
   output logic [4:0]           S_AXI_ACP_0_ARUSER,
   // R
   input  logic                 S_AXI_ACP_0_RVALID,
   output logic                 S_AXI_ACP_0_RREADY,
   input  logic [DATA_W-1:0]    S_AXI_ACP_0_RDATA,
   input  logic [1:0]           S_AXI_ACP_0_RRESP,
   input  logic                 S_AXI_ACP_0_RLAST,
   input  logic [ID_W-1:0]      S_AXI_ACP_0_RID
);

   localparam int          SIZE      = $clog2(DATA_W / 8);
   localparam logic [4:0]  LAST_CNT  = 5'(BURST_LEN - 1);
   localparam logic [31:0] ADDR_MASK = ~32'(DATA_W / 8 - 1);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

   w_state_t          w_state_q, w_state_d;
   logic [31:0]       w_addr_q, w_addr_d;
   logic [ID_W-1:0]   w_id_q, w_id_d;
   logic [4:0]        w_cnt_q, w_cnt_d;
   logic              tx_done_q, tx_done_d, tx_err_q, tx_err_d;

   r_state_t          r_state_q, r_state_d;
   logic [31:0]       r_addr_q, r_addr_d;
   logic [ID_W-1:0]   r_id_q, r_id_d;
   logic [4:0]        r_cnt_q, r_cnt_d;
   logic              r_acc_q, r_acc_d, r_beat_err;
   logic              rx_done_q, rx_done_d, rx_err_q, rx_err_d;

   // Response IDs are not checked: only one ID is ever outstanding per engine.
   logic unused_ids;
   assign unused_ids = ^{S_AXI_ACP_0_BID, S_AXI_ACP_0_RID};

   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_id_d    = w_id_q;
      w_cnt_d   = w_cnt_q;
      tx_done_d = 1'b0;
      tx_err_d  = 1'b0;
      case (w_state_q)
         W_IDLE: if (tx_en) begin
            w_addr_d  = tx_awaddr & ADDR_MASK;
            w_id_d    = tx_awid;
            w_cnt_d   = 5'd0;
            w_state_d = W_ADDR;
         end
         W_ADDR: if (S_AXI_ACP_0_AWREADY) w_state_d = W_DATA;
         W_DATA: if (S_AXI_ACP_0_WREADY) begin
            w_cnt_d = w_cnt_q + 5'd1;
            if (w_cnt_q == LAST_CNT) w_state_d = W_RESP;
         end
         W_RESP: if (S_AXI_ACP_0_BVALID) begin
            tx_done_d = 1'b1;
            tx_err_d  = |S_AXI_ACP_0_BRESP;
            w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_id_q    <= '0;
         w_cnt_q   <= '0;
         tx_done_q <= 1'b0;
         tx_err_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_id_q    <= w_id_d;
         w_cnt_q   <= w_cnt_d;
         tx_done_q <= tx_done_d;
         tx_err_q  <= tx_err_d;
      end
   end

   // Beat error: bad response, early rlast, or missing rlast on the final beat.
   assign r_beat_err = (|S_AXI_ACP_0_RRESP)
                     | (S_AXI_ACP_0_RLAST && (r_cnt_q != LAST_CNT))
                     | (!S_AXI_ACP_0_RLAST && (r_cnt_q == LAST_CNT));

   always_comb begin
      r_state_d = r_state_q;
      r_addr_d  = r_addr_q;
      r_id_d    = r_id_q;
      r_cnt_d   = r_cnt_q;
      r_acc_d   = r_acc_q;
      rx_done_d = 1'b0;
      rx_err_d  = 1'b0;
      case (r_state_q)
         R_IDLE: if (rx_en) begin
            r_addr_d  = rx_araddr & ADDR_MASK;
            r_id_d    = rx_arid;
            r_cnt_d   = 5'd0;
            r_acc_d   = 1'b0;
            r_state_d = R_ADDR;
         end
         R_ADDR: if (S_AXI_ACP_0_ARREADY) r_state_d = R_DATA;
         R_DATA: if (S_AXI_ACP_0_RVALID) begin
            r_cnt_d = r_cnt_q + 5'd1;
            r_acc_d = r_acc_q | r_beat_err;
            if (S_AXI_ACP_0_RLAST) begin
               rx_done_d = 1'b1;
               rx_err_d  = r_acc_q | r_beat_err;
               r_acc_d   = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_id_q    <= '0;
         r_cnt_q   <= '0;
         r_acc_q   <= 1'b0;
         rx_done_q <= 1'b0;
         rx_err_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_id_q    <= r_id_d;
         r_cnt_q   <= r_cnt_d;
         r_acc_q   <= r_acc_d;
         rx_done_q <= rx_done_d;
         rx_err_q  <= rx_err_d;
      end
   end

   assign tx_rdy   = (w_state_q == W_IDLE);
   assign tx_done  = tx_done_q;
   assign tx_err   = tx_err_q;
   assign tx_wdreq = S_AXI_ACP_0_WVALID & S_AXI_ACP_0_WREADY;

   assign S_AXI_ACP_0_AWVALID = (w_state_q == W_ADDR);
   assign S_AXI_ACP_0_AWADDR  = w_addr_q;
   assign S_AXI_ACP_0_AWID    = w_id_q;
   assign S_AXI_ACP_0_AWLEN   = LAST_CNT[3:0];
   assign S_AXI_ACP_0_AWSIZE  = 3'(SIZE);
   assign S_AXI_ACP_0_AWBURST = 2'b01;
   assign S_AXI_ACP_0_AWLOCK  = 2'b00;
   assign S_AXI_ACP_0_AWCACHE = AXCACHE;
   assign S_AXI_ACP_0_AWPROT  = 3'b000;
   assign S_AXI_ACP_0_AWQOS   = 4'b0000;
   assign S_AXI_ACP_0_AWUSER  = AXUSER;

   assign S_AXI_ACP_0_WVALID  = (w_state_q == W_DATA);
   assign S_AXI_ACP_0_WDATA   = tx_wdata;
   assign S_AXI_ACP_0_WSTRB   = '1;
   assign S_AXI_ACP_0_WLAST   = (w_state_q == W_DATA) && (w_cnt_q == LAST_CNT);
   assign S_AXI_ACP_0_WID     = w_id_q;
   assign S_AXI_ACP_0_BREADY  = (w_state_q == W_RESP);

   assign rx_rdy    = (r_state_q == R_IDLE);
   assign rx_done   = rx_done_q;
   assign rx_err    = rx_err_q;
   assign rx_rvalid = (r_state_q == R_DATA) & S_AXI_ACP_0_RVALID;
   assign rx_rdata  = S_AXI_ACP_0_RDATA;

   assign S_AXI_ACP_0_ARVALID = (r_state_q == R_ADDR);
   assign S_AXI_ACP_0_ARADDR  = r_addr_q;
   assign S_AXI_ACP_0_ARID    = r_id_q;
   assign S_AXI_ACP_0_ARLEN   = LAST_CNT[3:0];
   assign S_AXI_ACP_0_ARSIZE  = 3'(SIZE);
   assign S_AXI_ACP_0_ARBURST = 2'b01;
   assign S_AXI_ACP_0_ARLOCK  = 2'b00;
   assign S_AXI_ACP_0_ARCACHE = AXCACHE;
   assign S_AXI_ACP_0_ARPROT  = 3'b000;
   assign S_AXI_ACP_0_ARQOS   = 4'b0000;
   assign S_AXI_ACP_0_ARUSER  = AXUSER;
   assign S_AXI_ACP_0_RREADY  = (r_state_q == R_DATA);

endmodule

// File: tb/tb_tc_ps_acp_rw.sv
// Directed bench for tc_ps_acp_rw: instance a (64-bit, 16 beats), b (32-bit,
// 4 beats, reads) and c (32-bit, single beat).
module tb_tc_ps_acp_rw;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- instance a ----------------
   logic        a_tx_en = 0, a_tx_rdy, a_tx_wdreq, a_tx_done, a_tx_err;
   logic [31:0] a_tx_awaddr = 0;
   logic [2:0]  a_tx_awid = 0;
   logic [63:0] a_tx_wdata = 0;
   logic        a_rx_en = 0, a_rx_rdy, a_rx_rvalid, a_rx_done, a_rx_err;
   logic [31:0] a_rx_araddr = 0;
   logic [2:0]  a_rx_arid = 0;
   logic [63:0] a_rx_rdata;
   logic        a_awvalid, a_awready = 0, a_wvalid, a_wready = 0, a_wlast;
   logic [31:0] a_awaddr, a_araddr;
   logic [2:0]  a_awid, a_wid, a_arid, a_awsize, a_awprot, a_arsize, a_arprot;
   logic [3:0]  a_awlen, a_awcache, a_awqos, a_arlen, a_arcache, a_arqos;
   logic [1:0]  a_awburst, a_awlock, a_arburst, a_arlock;
   logic [4:0]  a_awuser, a_aruser;
   logic [63:0] a_wdata;
   logic [7:0]  a_wstrb;
   logic        a_bvalid = 0, a_bready, a_arvalid, a_arready = 0;
   logic [1:0]  a_bresp = 0, a_rresp = 0;
   logic        a_rvalid = 0, a_rready, a_rlast = 0;
   logic [63:0] a_rdata = 0;

   tc_ps_acp_rw #(.DATA_W(64), .ID_W(3), .BURST_LEN(16)) u_a (
      .clk(clk), .rst(rst),
      .tx_en(a_tx_en), .tx_rdy(a_tx_rdy), .tx_awaddr(a_tx_awaddr), .tx_awid(a_tx_awid),
      .tx_wdata(a_tx_wdata), .tx_wdreq(a_tx_wdreq), .tx_done(a_tx_done), .tx_err(a_tx_err),
      .rx_en(a_rx_en), .rx_rdy(a_rx_rdy), .rx_araddr(a_rx_araddr), .rx_arid(a_rx_arid),
      .rx_rdata(a_rx_rdata), .rx_rvalid(a_rx_rvalid), .rx_done(a_rx_done), .rx_err(a_rx_err),
      .S_AXI_ACP_0_AWVALID(a_awvalid), .S_AXI_ACP_0_AWREADY(a_awready),
      .S_AXI_ACP_0_AWADDR(a_awaddr), .S_AXI_ACP_0_AWID(a_awid), .S_AXI_ACP_0_AWLEN(a_awlen),
      .S_AXI_ACP_0_AWSIZE(a_awsize), .S_AXI_ACP_0_AWBURST(a_awburst),
      .S_AXI_ACP_0_AWLOCK(a_awlock), .S_AXI_ACP_0_AWCACHE(a_awcache),
      .S_AXI_ACP_0_AWPROT(a_awprot), .S_AXI_ACP_0_AWQOS(a_awqos), .S_AXI_ACP_0_AWUSER(a_awuser),
      .S_AXI_ACP_0_WVALID(a_wvalid), .S_AXI_ACP_0_WREADY(a_wready), .S_AXI_ACP_0_WDATA(a_wdata),
      .S_AXI_ACP_0_WSTRB(a_wstrb), .S_AXI_ACP_0_WLAST(a_wlast), .S_AXI_ACP_0_WID(a_wid),
      .S_AXI_ACP_0_BVALID(a_bvalid), .S_AXI_ACP_0_BREADY(a_bready),
      .S_AXI_ACP_0_BRESP(a_bresp), .S_AXI_ACP_0_BID(a_awid),
      .S_AXI_ACP_0_ARVALID(a_arvalid), .S_AXI_ACP_0_ARREADY(a_arready),
      .S_AXI_ACP_0_ARADDR(a_araddr), .S_AXI_ACP_0_ARID(a_arid), .S_AXI_ACP_0_ARLEN(a_arlen),
      .S_AXI_ACP_0_ARSIZE(a_arsize), .S_AXI_ACP_0_ARBURST(a_arburst),
      .S_AXI_ACP_0_ARLOCK(a_arlock), .S_AXI_ACP_0_ARCACHE(a_arcache),
      .S_AXI_ACP_0_ARPROT(a_arprot), .S_AXI_ACP_0_ARQOS(a_arqos), .S_AXI_ACP_0_ARUSER(a_aruser),
      .S_AXI_ACP_0_RVALID(a_rvalid), .S_AXI_ACP_0_RREADY(a_rready), .S_AXI_ACP_0_RDATA(a_rdata),
      .S_AXI_ACP_0_RRESP(a_rresp), .S_AXI_ACP_0_RLAST(a_rlast), .S_AXI_ACP_0_RID(a_arid)
   );

   // ---------------- instance b ----------------
   logic        b_tx_rdy, b_tx_wdreq, b_tx_done, b_tx_err;
   logic        b_rx_en = 0, b_rx_rdy, b_rx_rvalid, b_rx_done, b_rx_err;
   logic [31:0] b_rx_araddr = 0;
   logic [2:0]  b_rx_arid = 0;
   logic [31:0] b_rx_rdata;
   logic        b_awvalid, b_wvalid, b_wlast, b_bready, b_arvalid, b_arready = 0, b_rready;
   logic [31:0] b_awaddr, b_araddr, b_wdata;
   logic [2:0]  b_awid, b_wid, b_arid, b_awsize, b_awprot, b_arsize, b_arprot;
   logic [3:0]  b_awlen, b_awcache, b_awqos, b_arlen, b_arcache, b_arqos, b_wstrb;
   logic [1:0]  b_awburst, b_awlock, b_arburst, b_arlock;
   logic [4:0]  b_awuser, b_aruser;
   logic        b_rvalid = 0, b_rlast = 0;
   logic [1:0]  b_rresp = 0;
   logic [31:0] b_rdata = 0;

   tc_ps_acp_rw #(.DATA_W(32), .ID_W(3), .BURST_LEN(4)) u_b (
      .clk(clk), .rst(rst),
      .tx_en(1'b0), .tx_rdy(b_tx_rdy), .tx_awaddr(32'd0), .tx_awid(3'd0),
      .tx_wdata(32'd0), .tx_wdreq(b_tx_wdreq), .tx_done(b_tx_done), .tx_err(b_tx_err),
      .rx_en(b_rx_en), .rx_rdy(b_rx_rdy), .rx_araddr(b_rx_araddr), .rx_arid(b_rx_arid),
      .rx_rdata(b_rx_rdata), .rx_rvalid(b_rx_rvalid), .rx_done(b_rx_done), .rx_err(b_rx_err),
      .S_AXI_ACP_0_AWVALID(b_awvalid), .S_AXI_ACP_0_AWREADY(1'b0),
      .S_AXI_ACP_0_AWADDR(b_awaddr), .S_AXI_ACP_0_AWID(b_awid), .S_AXI_ACP_0_AWLEN(b_awlen),
      .S_AXI_ACP_0_AWSIZE(b_awsize), .S_AXI_ACP_0_AWBURST(b_awburst),
      .S_AXI_ACP_0_AWLOCK(b_awlock), .S_AXI_ACP_0_AWCACHE(b_awcache),
      .S_AXI_ACP_0_AWPROT(b_awprot), .S_AXI_ACP_0_AWQOS(b_awqos), .S_AXI_ACP_0_AWUSER(b_awuser),
      .S_AXI_ACP_0_WVALID(b_wvalid), .S_AXI_ACP_0_WREADY(1'b0), .S_AXI_ACP_0_WDATA(b_wdata),
      .S_AXI_ACP_0_WSTRB(b_wstrb), .S_AXI_ACP_0_WLAST(b_wlast), .S_AXI_ACP_0_WID(b_wid),
      .S_AXI_ACP_0_BVALID(1'b0), .S_AXI_ACP_0_BREADY(b_bready),
      .S_AXI_ACP_0_BRESP(2'b00), .S_AXI_ACP_0_BID(3'd0),
      .S_AXI_ACP_0_ARVALID(b_arvalid), .S_AXI_ACP_0_ARREADY(b_arready),
      .S_AXI_ACP_0_ARADDR(b_araddr), .S_AXI_ACP_0_ARID(b_arid), .S_AXI_ACP_0_ARLEN(b_arlen),
      .S_AXI_ACP_0_ARSIZE(b_arsize), .S_AXI_ACP_0_ARBURST(b_arburst),
      .S_AXI_ACP_0_ARLOCK(b_arlock), .S_AXI_ACP_0_ARCACHE(b_arcache),
      .S_AXI_ACP_0_ARPROT(b_arprot), .S_AXI_ACP_0_ARQOS(b_arqos), .S_AXI_ACP_0_ARUSER(b_aruser),
      .S_AXI_ACP_0_RVALID(b_rvalid), .S_AXI_ACP_0_RREADY(b_rready), .S_AXI_ACP_0_RDATA(b_rdata),
      .S_AXI_ACP_0_RRESP(b_rresp), .S_AXI_ACP_0_RLAST(b_rlast), .S_AXI_ACP_0_RID(b_arid)
   );

   // ---------------- instance c ----------------
   logic        c_tx_en = 0, c_tx_rdy, c_tx_wdreq, c_tx_done, c_tx_err;
   logic [31:0] c_tx_awaddr = 0;
   logic        c_rx_rdy, c_rx_rvalid, c_rx_done, c_rx_err;
   logic [31:0] c_rx_rdata;
   logic        c_awvalid, c_wvalid, c_wlast, c_bready, c_arvalid, c_rready;
   logic        c_bvalid = 0;
   logic [31:0] c_awaddr, c_araddr, c_wdata;
   logic [2:0]  c_awid, c_wid, c_arid, c_awsize, c_awprot, c_arsize, c_arprot;
   logic [3:0]  c_awlen, c_awcache, c_awqos, c_arlen, c_arcache, c_arqos, c_wstrb;
   logic [1:0]  c_awburst, c_awlock, c_arburst, c_arlock;
   logic [4:0]  c_awuser, c_aruser;

   tc_ps_acp_rw #(.DATA_W(32), .ID_W(3), .BURST_LEN(1)) u_c (
      .clk(clk), .rst(rst),
      .tx_en(c_tx_en), .tx_rdy(c_tx_rdy), .tx_awaddr(c_tx_awaddr), .tx_awid(3'd1),
      .tx_wdata(32'h1234_5678), .tx_wdreq(c_tx_wdreq), .tx_done(c_tx_done), .tx_err(c_tx_err),
      .rx_en(1'b0), .rx_rdy(c_rx_rdy), .rx_araddr(32'd0), .rx_arid(3'd0),
      .rx_rdata(c_rx_rdata), .rx_rvalid(c_rx_rvalid), .rx_done(c_rx_done), .rx_err(c_rx_err),
      .S_AXI_ACP_0_AWVALID(c_awvalid), .S_AXI_ACP_0_AWREADY(1'b1),
      .S_AXI_ACP_0_AWADDR(c_awaddr), .S_AXI_ACP_0_AWID(c_awid), .S_AXI_ACP_0_AWLEN(c_awlen),
      .S_AXI_ACP_0_AWSIZE(c_awsize), .S_AXI_ACP_0_AWBURST(c_awburst),
      .S_AXI_ACP_0_AWLOCK(c_awlock), .S_AXI_ACP_0_AWCACHE(c_awcache),
      .S_AXI_ACP_0_AWPROT(c_awprot), .S_AXI_ACP_0_AWQOS(c_awqos), .S_AXI_ACP_0_AWUSER(c_awuser),
      .S_AXI_ACP_0_WVALID(c_wvalid), .S_AXI_ACP_0_WREADY(1'b1), .S_AXI_ACP_0_WDATA(c_wdata),
      .S_AXI_ACP_0_WSTRB(c_wstrb), .S_AXI_ACP_0_WLAST(c_wlast), .S_AXI_ACP_0_WID(c_wid),
      .S_AXI_ACP_0_BVALID(c_bvalid), .S_AXI_ACP_0_BREADY(c_bready),
      .S_AXI_ACP_0_BRESP(2'b00), .S_AXI_ACP_0_BID(3'd1),
      .S_AXI_ACP_0_ARVALID(c_arvalid), .S_AXI_ACP_0_ARREADY(1'b0),
      .S_AXI_ACP_0_ARADDR(c_araddr), .S_AXI_ACP_0_ARID(c_arid), .S_AXI_ACP_0_ARLEN(c_arlen),
      .S_AXI_ACP_0_ARSIZE(c_arsize), .S_AXI_ACP_0_ARBURST(c_arburst),
      .S_AXI_ACP_0_ARLOCK(c_arlock), .S_AXI_ACP_0_ARCACHE(c_arcache),
      .S_AXI_ACP_0_ARPROT(c_arprot), .S_AXI_ACP_0_ARQOS(c_arqos), .S_AXI_ACP_0_ARUSER(c_aruser),
      .S_AXI_ACP_0_RVALID(1'b0), .S_AXI_ACP_0_RREADY(c_rready), .S_AXI_ACP_0_RDATA(32'd0),
      .S_AXI_ACP_0_RRESP(2'b00), .S_AXI_ACP_0_RLAST(1'b0), .S_AXI_ACP_0_RID(3'd0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [63:0] cap [16];
   int beats, wl_cnt, wl_beat, pulses;

   initial begin
      // ---- reset ----
      step(); step(); step();
      chk("rst_awvalid", a_awvalid, 0);
      chk("rst_txdone", a_tx_done, 0);
      rst = 1'b1;
      step();
      chk("rst_txrdy", a_tx_rdy, 1);
      chk("rst_rxrdy", a_rx_rdy, 1);
      chk("rst_valids", {a_wvalid, a_bready, a_arvalid, a_rready}, 4'b0000);
      $display("[TB] reset checked");

      // ---- single write, all readies high ----
      a_awready = 1; a_wready = 1;
      a_tx_en = 1; a_tx_awaddr = 32'h1000_0007; a_tx_awid = 3'd3;
      step();
      a_tx_en = 0;
      chk("w1_txrdy", a_tx_rdy, 0);
      chk("w1_awvalid", a_awvalid, 1);
      chk("w1_awaddr", a_awaddr, 64'h1000_0000);
      chk("w1_awlen", a_awlen, 15);
      chk("w1_awsize", a_awsize, 3);
      chk("w1_awid", a_awid, 3);
      chk("w1_awconst", {a_awburst, a_awcache, a_awuser, a_awlock, a_awprot, a_awqos},
          {2'b01, 4'b1111, 5'b00001, 2'b00, 3'b000, 4'b0000});
      step();
      chk("w1_wvalid", a_wvalid, 1);
      chk("w1_wid", a_wid, 3);
      chk("w1_wstrb", a_wstrb, 8'hFF);
      pulses = 0; wl_cnt = 0; wl_beat = 0;
      for (int i = 0; i < 16; i++) begin
         if (a_tx_wdreq) pulses++;
         if (a_wlast) begin wl_cnt++; wl_beat = i + 1; end
         if (i == 8) chk("w1_bready_data", a_bready, 0);
         step();
      end
      chk("w1_wdreq_pulses", pulses, 16);
      chk("w1_wlast_count", wl_cnt, 1);
      chk("w1_wlast_beat", wl_beat, 16);
      chk("w1_bready", a_bready, 1);
      chk("w1_wvalid_off", a_wvalid, 0);
      a_bvalid = 1; a_bresp = 2'b00;
      step();
      a_bvalid = 0;
      chk("w1_txdone", a_tx_done, 1);
      chk("w1_txerr", a_tx_err, 0);
      chk("w1_txrdy_back", a_tx_rdy, 1);
      step();
      chk("w1_txdone_pulse", a_tx_done, 0);
      $display("[TB] write 1 done: %0d beats", pulses);

      // ---- write with wready toggling, data 0..15, bresp SLVERR ----
      a_tx_en = 1; a_tx_awaddr = 32'h1000_0100; a_tx_awid = 3'd5;
      step();
      a_tx_en = 0;
      step();
      beats = 0; wl_cnt = 0; wl_beat = 0;
      a_wready = 0;
      for (int cyc = 0; cyc < 40 && beats < 16; cyc++) begin
         a_wready = ~a_wready;
         a_tx_wdata = 64'(beats);
         if (a_wvalid && a_wready) begin
            cap[beats] = a_wdata;
            if (a_wlast) begin wl_cnt++; wl_beat = beats + 1; end
            beats++;
         end
         step();
      end
      a_wready = 1;
      chk("w2_beats", beats, 16);
      for (int k = 0; k < 16; k++) chk("w2_data_order", cap[k], 64'(k));
      chk("w2_wlast_count", wl_cnt, 1);
      chk("w2_wlast_beat", wl_beat, 16);
      a_bvalid = 1; a_bresp = 2'b10;
      step();
      a_bvalid = 0; a_bresp = 2'b00;
      chk("w2_txdone", a_tx_done, 1);
      chk("w2_txerr", a_tx_err, 1);
      $display("[TB] write 2 done: %0d beats, err=%0b", beats, a_tx_err);
      step();

      // ---- reads on instance b (4 beats) ----
      b_rx_en = 1; b_rx_araddr = 32'h2000_0006; b_rx_arid = 3'd6;
      step();
      b_rx_en = 0;
      chk("r1_arvalid", b_arvalid, 1);
      chk("r1_araddr", b_araddr, 64'h2000_0004);
      chk("r1_arlen", b_arlen, 3);
      chk("r1_arsize", b_arsize, 2);
      chk("r1_arid", b_arid, 6);
      chk("r1_rxrdy", b_rx_rdy, 0);
      step();
      chk("r1_arvalid_held", b_arvalid, 1);
      chk("r1_araddr_held", b_araddr, 64'h2000_0004);
      b_arready = 1;
      step();
      b_arready = 0;
      chk("r1_rready", b_rready, 1);
      for (int i = 0; i < 4; i++) begin
         b_rvalid = 1; b_rdata = 32'hC0DE_0000 + 32'(i); b_rlast = (i == 3);
         #1;
         chk("r1_rvalid", b_rx_rvalid, 1);
         chk("r1_rdata", b_rx_rdata, 64'hC0DE_0000 + 64'(i));
         step();
      end
      b_rvalid = 0; b_rlast = 0;
      chk("r1_rxdone", b_rx_done, 1);
      chk("r1_rxerr", b_rx_err, 0);
      chk("r1_rxrdy_back", b_rx_rdy, 1);
      step();
      chk("r1_rxdone_pulse", b_rx_done, 0);
      $display("[TB] read 1 done");

      b_rx_en = 1; b_rx_araddr = 32'h2000_0100;
      step();
      b_rx_en = 0; b_arready = 1;
      step();
      b_arready = 0;
      for (int i = 0; i < 3; i++) begin
         b_rvalid = 1; b_rdata = 32'(i); b_rlast = (i == 2);
         step();
      end
      b_rvalid = 0; b_rlast = 0;
      chk("r2_rxdone", b_rx_done, 1);
      chk("r2_rxerr_early_last", b_rx_err, 1);
      $display("[TB] read 2 (early rlast) done, err=%0b", b_rx_err);
      step();

      // ---- concurrent write and read on instance a ----
      a_arready = 1;
      a_tx_en = 1; a_tx_awaddr = 32'h4000_0008; a_tx_awid = 3'd2;
      a_rx_en = 1; a_rx_araddr = 32'h5000_0010; a_rx_arid = 3'd4;
      step();
      a_tx_en = 0; a_rx_en = 0;
      chk("c_awvalid", a_awvalid, 1);
      chk("c_arvalid", a_arvalid, 1);
      chk("c_araddr", a_araddr, 64'h5000_0010);
      step();
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         a_rvalid = 1; a_rdata = 64'hA0 + 64'(i); a_rlast = (i == 15);
         if (i == 3) begin a_tx_en = 1; a_tx_awaddr = 32'h5555_0000; end
         if (i == 6) a_tx_en = 0;
         #1;
         if (i == 5) begin
            chk("c_busy_awvalid", a_awvalid, 0);
            chk("c_busy_txrdy", a_tx_rdy, 0);
         end
         if (a_rx_rvalid && a_rx_rdata == 64'hA0 + 64'(i)) pulses++;
         if (a_tx_wdreq) pulses++;
         step();
      end
      a_rvalid = 0; a_rlast = 0;
      chk("c_beats", pulses, 32);
      chk("c_rxdone", a_rx_done, 1);
      chk("c_rxerr", a_rx_err, 0);
      a_bvalid = 1;
      step();
      a_bvalid = 0;
      chk("c_txdone", a_tx_done, 1);
      chk("c_txerr", a_tx_err, 0);
      chk("c_rxdone_pulse", a_rx_done, 0);
      chk("c_no_reissue", a_awvalid, 0);
      $display("[TB] concurrent write/read done");
      step();

      // ---- reset in the middle of W_DATA ----
      a_tx_en = 1; a_tx_awaddr = 32'h6000_0000;
      step();
      a_tx_en = 0;
      step();
      for (int i = 0; i < 5; i++) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mr_valids", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready}, 5'b00000);
      chk("mr_txrdy", a_tx_rdy, 1);
      chk("mr_txdone", a_tx_done, 0);
      a_bvalid = 1;
      step();
      a_bvalid = 0;
      chk("mr_txdone_after", a_tx_done, 0);
      a_tx_en = 1;
      step();
      a_tx_en = 0;
      step();
      wl_cnt = 0; wl_beat = 0;
      for (int i = 0; i < 16; i++) begin
         if (a_wlast) begin wl_cnt++; wl_beat = i + 1; end
         step();
      end
      chk("mr_fresh_wlast_beat", wl_beat, 16);
      chk("mr_fresh_wlast_count", wl_cnt, 1);
      a_bvalid = 1;
      step();
      a_bvalid = 0;
      chk("mr_fresh_txdone", a_tx_done, 1);
      $display("[TB] mid-burst reset checked");

      // ---- instance c: DATA_W=32, BURST_LEN=1 ----
      c_tx_en = 1; c_tx_awaddr = 32'h0000_0003;
      step();
      c_tx_en = 0;
      chk("s_awaddr", c_awaddr, 0);
      chk("s_awsize", c_awsize, 2);
      chk("s_awlen", c_awlen, 0);
      step();
      chk("s_wvalid", c_wvalid, 1);
      chk("s_wlast", c_wlast, 1);
      chk("s_wstrb", c_wstrb, 4'hF);
      chk("s_wdata", c_wdata, 32'h1234_5678);
      step();
      chk("s_bready", c_bready, 1);
      c_bvalid = 1;
      step();
      c_bvalid = 0;
      chk("s_txdone", c_tx_done, 1);
      $display("[TB] single-beat write checked");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
